// File: rtl/mole_scheduler_concurrent.sv
// Multi-slot whack-a-mole scheduler: up to MAX_ACTIVE moles lit at once, each slot
// running its own ON/GAP timer on the 1 ms tick, with registered hit/miss pulse counts.
module mole_scheduler_concurrent #(
  parameter int N_MOLES    = 18,
  parameter int MAX_ACTIVE = 3,
  parameter int ON_MS_BASE = 900,
  parameter int ON_MS_STEP = 100,
  parameter int ON_MS_MIN  = 300,
  parameter int GAP_MS     = 250,
  parameter int LEVEL_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_active,
  input  logic               tick_1ms,
  input  logic [7:0]         rnd,
  input  logic [LEVEL_W-1:0] level,
  input  logic [N_MOLES-1:0] hit_mask,
  output logic [N_MOLES-1:0] active_mask,
  output logic [3:0]         n_active,
  output logic [3:0]         hit_count,
  output logic [3:0]         miss_count
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} slot_state_e;

  localparam logic [N_MOLES-1:0] ONE = N_MOLES'(1);
  localparam logic [7:0]         MOD = 8'(N_MOLES);

  slot_state_e  state_q [MAX_ACTIVE];
  slot_state_e  state_d [MAX_ACTIVE];
  logic [4:0]   idx_q   [MAX_ACTIVE];
  logic [4:0]   idx_d   [MAX_ACTIVE];
  logic [15:0]  cnt_q   [MAX_ACTIVE];
  logic [15:0]  cnt_d   [MAX_ACTIVE];

  logic [N_MOLES-1:0] active_mask_q, active_mask_d;
  logic [3:0]         n_active_q, n_active_d;
  logic [3:0]         hit_count_q, hit_count_d;
  logic [3:0]         miss_count_q, miss_count_d;

  logic [4:0]         cand;
  logic [15:0]        on_cnt;
  logic [N_MOLES-1:0] lit;
  logic               collide;
  logic               spawn_ok;
  logic               spawned;
  logic               slot_hit;

  // Saturates at ON_MS_MIN instead of wrapping when level*STEP exceeds BASE.
  function automatic logic [19:0] on_ms(input logic [LEVEL_W-1:0] lv);
    logic [19:0] prod;
    logic [19:0] diff;
    prod = 20'(lv) * 20'(ON_MS_STEP);
    if (prod >= 20'(ON_MS_BASE)) return 20'(ON_MS_MIN);
    diff = 20'(ON_MS_BASE) - prod;
    return (diff < 20'(ON_MS_MIN)) ? 20'(ON_MS_MIN) : diff;
  endfunction

  always_comb begin
    cand    = 5'(rnd % MOD);
    on_cnt  = 16'(on_ms(level));
    lit     = '0;
    for (int unsigned s = 0; s < MAX_ACTIVE; s++) begin
      if (state_q[s] == S_ON) lit = lit | (ONE << idx_q[s]);
    end
    collide      = |(lit & (ONE << cand));
    spawn_ok     = game_active && tick_1ms && !collide;
    spawned      = 1'b0;
    hit_count_d  = '0;
    miss_count_d = '0;

    for (int unsigned s = 0; s < MAX_ACTIVE; s++) begin
      state_d[s] = state_q[s];
      idx_d[s]   = idx_q[s];
      cnt_d[s]   = cnt_q[s];
      slot_hit   = (state_q[s] == S_ON) && |(hit_mask & (ONE << idx_q[s]));
      case (state_q[s])
        S_IDLE: begin
          if (spawn_ok && !spawned) begin
            state_d[s] = S_ON;
            idx_d[s]   = cand;
            cnt_d[s]   = on_cnt;
            spawned    = 1'b1;
          end
        end
        S_ON: begin
          if (slot_hit) begin
            state_d[s]  = S_GAP;
            cnt_d[s]    = 16'(GAP_MS);
            hit_count_d = hit_count_d + 4'd1;
          end else if (tick_1ms) begin
            if (cnt_q[s] == '0) begin
              state_d[s]   = S_GAP;
              cnt_d[s]     = 16'(GAP_MS);
              miss_count_d = miss_count_d + 4'd1;
            end else begin
              cnt_d[s] = cnt_q[s] - 16'd1;
            end
          end
        end
        S_GAP: begin
          if (tick_1ms) begin
            if (cnt_q[s] == '0) state_d[s] = S_IDLE;
            else                cnt_d[s]   = cnt_q[s] - 16'd1;
          end
        end
        default: state_d[s] = S_IDLE;
      endcase
      if (!game_active) begin
        state_d[s] = S_IDLE;
        idx_d[s]   = '0;
        cnt_d[s]   = '0;
      end
    end

    if (!game_active) begin
      hit_count_d  = '0;
      miss_count_d = '0;
    end

    // Outputs are derived from next state so they register on the same edge as the slots.
    active_mask_d = '0;
    n_active_d    = '0;
    for (int unsigned s = 0; s < MAX_ACTIVE; s++) begin
      if (state_d[s] == S_ON) begin
        active_mask_d = active_mask_d | (ONE << idx_d[s]);
        n_active_d    = n_active_d + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < MAX_ACTIVE; s++) begin
        state_q[s] <= S_IDLE;
        idx_q[s]   <= '0;
        cnt_q[s]   <= '0;
      end
      active_mask_q <= '0;
      n_active_q    <= '0;
      hit_count_q   <= '0;
      miss_count_q  <= '0;
    end else begin
      for (int unsigned s = 0; s < MAX_ACTIVE; s++) begin
        state_q[s] <= state_d[s];
        idx_q[s]   <= idx_d[s];
        cnt_q[s]   <= cnt_d[s];
      end
      active_mask_q <= active_mask_d;
      n_active_q    <= n_active_d;
      hit_count_q   <= hit_count_d;
      miss_count_q  <= miss_count_d;
    end
  end

  assign active_mask = active_mask_q;
  assign n_active    = n_active_q;
  assign hit_count   = hit_count_q;
  assign miss_count  = miss_count_q;

endmodule
